// File: rtl/seq_shifter_pkg.sv
// seq_shifter_pkg: shared mode and FSM state encodings for the sequential
// shift/rotate unit, plus a helper that classifies modes.
package seq_shifter_pkg;

  // Operation encodings (kept compatible with the 4-bit combinational shifter)
  localparam logic [2:0] MODE_PASS = 3'b000;
  localparam logic [2:0] MODE_SHL  = 3'b001;
  localparam logic [2:0] MODE_SHR  = 3'b010;
  localparam logic [2:0] MODE_SAR  = 3'b011;
  localparam logic [2:0] MODE_ROL  = 3'b100;
  localparam logic [2:0] MODE_ROR  = 3'b101;
  localparam logic [2:0] MODE_REV  = 3'b110;
  localparam logic [2:0] MODE_CLR  = 3'b111;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_SHIFT = 2'b01;
  localparam logic [1:0] ST_DONE  = 2'b10;

  // Modes that walk one bit per clock; the others resolve on the accept edge
  function automatic logic is_multi_cycle(input logic [2:0] mode);
    return !((mode == MODE_PASS) || (mode == MODE_REV) || (mode == MODE_CLR));
  endfunction

endpackage

// File: rtl/seq_shifter_step.sv
// seq_shifter_step: combinational single-position shift/rotate step.
// Produces the next working value and the bit that left the boundary.
// Non-shifting modes pass data through with a zero out bit.
module seq_shifter_step
  import seq_shifter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       mode,
  output logic [WIDTH-1:0] next_data,
  output logic             out_bit
);

  // One-position move selected by mode
  always_comb begin
    next_data = data;
    out_bit   = 1'b0;
    case (mode)
      MODE_SHL: begin
        next_data = {data[WIDTH-2:0], 1'b0};
        out_bit   = data[WIDTH-1];
      end
      MODE_SHR: begin
        next_data = {1'b0, data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      MODE_SAR: begin
        next_data = {data[WIDTH-1], data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      MODE_ROL: begin
        next_data = {data[WIDTH-2:0], data[WIDTH-1]};
        out_bit   = data[WIDTH-1];
      end
      MODE_ROR: begin
        next_data = {data[0], data[WIDTH-1:1]};
        out_bit   = data[0];
      end
      default: begin
        next_data = data;
        out_bit   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift/rotate engine, one bit position per clock.
// start is accepted in IDLE or DONE; busy is high in SHIFT, done pulses in DONE.
// Optional flags (zero, cout) are built when SEQ_SHIFTER_FLAGS_EN is defined.
module seq_shifter
  import seq_shifter_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int AW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [2:0]       mode,
  input  logic [AW-1:0]    amt,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done
`ifdef SEQ_SHIFTER_FLAGS_EN
  ,
  output logic             zero,
  output logic             cout
`endif
);

  if ((WIDTH < 4) || ((WIDTH & (WIDTH - 1)) != 0)) begin : g_bad_width
    $error("seq_shifter: WIDTH must be a power of two and at least 4");
  end

  localparam logic [AW-1:0] CNT_ONE = {{(AW-1){1'b0}}, 1'b1};

  logic [1:0]       state_r;
  logic [WIDTH-1:0] work_r;
  logic [AW-1:0]    cnt_r;
  logic [2:0]       mode_r;
  logic [WIDTH-1:0] rev_s;
  logic [WIDTH-1:0] load_s;
  logic [AW-1:0]    load_cnt_s;
  logic [WIDTH-1:0] step_data_s;
  logic             step_out_s;

  seq_shifter_step #(.WIDTH(WIDTH)) u_step (
    .data      (work_r),
    .mode      (mode_r),
    .next_data (step_data_s),
    .out_bit   (step_out_s)
  );

  // Bit-reversed operand for the reverse mode
  always_comb begin
    rev_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      rev_s[i] = a[WIDTH-1-i];
    end
  end

  // Working value and count loaded on the accept edge
  always_comb begin
    load_s     = a;
    load_cnt_s = '0;
    if (is_multi_cycle(mode)) begin
      load_s     = a;
      load_cnt_s = amt;
    end else if (mode == MODE_REV) begin
      load_s     = rev_s;
      load_cnt_s = '0;
    end else if (mode == MODE_CLR) begin
      load_s     = '0;
      load_cnt_s = '0;
    end else begin
      load_s     = a;
      load_cnt_s = '0;
    end
  end

`ifdef SEQ_SHIFTER_FLAGS_EN
  logic last_r;

  // Last bit shifted out; cleared on accept so zero-step ops report 0
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= 1'b0;
    end else if (((state_r == ST_IDLE) || (state_r == ST_DONE)) && start) begin
      last_r <= 1'b0;
    end else if ((state_r == ST_SHIFT) && (cnt_r != '0)) begin
      last_r <= step_out_s;
    end else begin
      last_r <= last_r;
    end
  end

  // Flags update together with r when an operation completes
  always_ff @(posedge clk) begin
    if (rst) begin
      zero <= 1'b0;
      cout <= 1'b0;
    end else if ((state_r == ST_SHIFT) && (cnt_r == '0)) begin
      zero <= (work_r == '0);
      cout <= last_r;
    end else begin
      zero <= zero;
      cout <= cout;
    end
  end
`else
  logic unused_s;
  assign unused_s = step_out_s;
`endif

  // Control FSM, working register, counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      work_r  <= '0;
      cnt_r   <= '0;
      mode_r  <= MODE_PASS;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_r <= ST_SHIFT;
            work_r  <= load_s;
            cnt_r   <= load_cnt_s;
            mode_r  <= mode;
            busy    <= 1'b1;
            done    <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          if (cnt_r != '0) begin
            work_r <= step_data_s;
            cnt_r  <= cnt_r - CNT_ONE;
          end else begin
            r       <= work_r;
            state_r <= ST_DONE;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard bench for seq_shifter (WIDTH=8).
// Driver pushes expected results from an arithmetic reference model;
// a monitor pops and compares whenever done is seen.
module tb_seq_shifter;

  localparam int W  = 8;
  localparam int AW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [W-1:0]  a;
  logic [2:0]    mode;
  logic [AW-1:0] amt;
  logic [W-1:0]  r;
  logic          busy;
  logic          done;
  logic          zero;
  logic          cout;

  seq_shifter #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .mode  (mode),
    .amt   (amt),
    .r     (r),
    .busy  (busy),
    .done  (done)
`ifdef SEQ_SHIFTER_FLAGS_EN
    ,
    .zero  (zero),
    .cout  (cout)
`endif
  );

`ifndef SEQ_SHIFTER_FLAGS_EN
  assign zero = 1'b0;
  assign cout = 1'b0;
`endif

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] r;
    logic         z;
    logic         c;
    int           lat;
    int           acc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cycle_cnt = 0;
  int   done_seen = 0;

  always @(posedge clk) cycle_cnt <= cycle_cnt + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle_cnt);
    end
  endtask

  // Reference model: result from plain operators, latency from the mode rules
  function automatic exp_t model(input logic [W-1:0] av, input logic [2:0] m,
                                 input int k, input int acc);
    exp_t e;
    logic signed [W-1:0] sa;
    sa    = av;
    e.acc = acc;
    e.lat = k + 1;
    e.c   = 1'b0;
    e.r   = '0;
    case (m)
      3'd0: begin e.r = av; e.lat = 1; end
      3'd1: begin e.r = av << k; if (k > 0) e.c = av[W-k]; end
      3'd2: begin e.r = av >> k; if (k > 0) e.c = av[k-1]; end
      3'd3: begin e.r = sa >>> k; if (k > 0) e.c = av[k-1]; end
      3'd4: begin e.r = (av << k) | (av >> (W - k)); if (k > 0) e.c = av[W-k]; end
      3'd5: begin e.r = (av >> k) | (av << (W - k)); if (k > 0) e.c = av[k-1]; end
      3'd6: begin for (int i = 0; i < W; i++) e.r[i] = av[W-1-i]; e.lat = 1; end
      default: begin e.r = '0; e.lat = 1; end
    endcase
    e.z = (e.r == '0);
    return e;
  endfunction

  // Monitor: compare every done pulse against the oldest expectation
  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      done_seen++;
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)", cycle_cnt);
      end else begin
        e = exp_q.pop_front();
        chk("result_r", r, e.r);
        chk("latency", cycle_cnt - e.acc, e.lat);
        chk("busy_at_done", busy, 1'b0);
`ifdef SEQ_SHIFTER_FLAGS_EN
        chk("zero_flag", zero, e.z);
        chk("cout_flag", cout, e.c);
`endif
      end
    end
  end

  // Drive one op at the current negedge; caller is positioned at a negedge
  task automatic run_op(input logic [W-1:0] av, input logic [2:0] m, input int k);
    start = 1'b1;
    a     = av;
    mode  = m;
    amt   = AW'(k);
    exp_q.push_back(model(av, m, k, cycle_cnt + 1));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
  endtask

  // Bounded wait for done; leaves the bench at the done negedge
  task automatic wait_done();
    for (int i = 0; i < 40; i++) begin
      if (done === 1'b1) return;
      @(negedge clk);
    end
    n_cmp++;
    n_fail++;
    $display("FAIL timeout: got no done expected done within 40 cycles");
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'hFF;
    mode  = 3'b001;
    amt   = 3'd3;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_r", r, 8'h00);
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_zero", zero, 1'b0);
    chk("reset_cout", cout, 1'b0);
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    chk("idle_after_reset", busy, 1'b0);

    // Directed cases
    run_op(8'b1001_0110, 3'b001, 3); wait_done();
    run_op(8'b1000_0001, 3'b011, 2); wait_done();
    run_op(8'h81, 3'b101, 1);        wait_done();
    run_op(8'b0000_0110, 3'b110, 0); wait_done();
    run_op(8'h37, 3'b111, 4);        wait_done();
    run_op(8'h5A, 3'b000, 7);        wait_done();
    run_op(8'hA5, 3'b010, 0);        wait_done();
    @(negedge clk);

    // start held through SHIFT with a different operand: ignored
    start = 1'b1;
    a     = 8'h3C;
    mode  = 3'b001;
    amt   = 3'd5;
    exp_q.push_back(model(8'h3C, 3'b001, 5, cycle_cnt + 1));
    @(posedge clk);
    @(negedge clk);
    chk("busy_hold", busy, 1'b1);
    a    = 8'hFF;
    mode = 3'b101;
    amt  = 3'd1;
    repeat (2) @(negedge clk);
    start = 1'b0;
    wait_done();

    // Back-to-back from the DONE cycle
    run_op(8'hC3, 3'b100, 3); wait_done();
    run_op(8'h0F, 3'b010, 6); wait_done();
    @(negedge clk);

    // Randomized ops, mixing back-to-back and idle gaps
    for (int n = 0; n < 40; n++) begin
      run_op(W'($urandom), 3'($urandom_range(0, 7)), $urandom_range(0, 7));
      wait_done();
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    if (done === 1'b1) @(negedge clk);

    // Reset mid-operation aborts with no done
    start = 1'b1;
    a     = 8'h01;
    mode  = 3'b100;
    amt   = 3'd7;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_r", r, 8'h00);
    chk("abort_busy", busy, 1'b0);
    chk("abort_done", done, 1'b0);
    done_seen = 0;
    repeat (15) @(negedge clk);
    chk("abort_no_done", done_seen, 0);

    chk("queue_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
